// File: rtl/alu_nibble_sequencer_if.sv
// Bundle between the nibble sequencer, its requester (operands, flags, handshake)
// and the downstream 4-bit ALU slice.
interface alu_nibble_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [2:0]   func;
    logic         com;
    logic         cin;
    logic [W-1:0] opa;
    logic [W-1:0] opb;

    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [2:0]   alu_f;
    logic         alu_com;
    logic         alu_ci_right;
    logic         alu_ci_left;
    logic [3:0]   alu_d;
    logic         alu_co_left;
    logic         alu_co_right;
    logic         alu_equ;

    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         neg_zero;
    logic         equal;
    logic         busy;
    logic         done;

    // The sequencer is the slave of the requester and the master of the slice.
    modport slave (
        input  start, func, com, cin, opa, opb,
        input  alu_d, alu_co_left, alu_co_right, alu_equ,
        output alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left,
        output result, cout, zero, neg_zero, equal, busy, done
    );

    modport master (
        output start, func, com, cin, opa, opb,
        output alu_d, alu_co_left, alu_co_right, alu_equ,
        input  alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left,
        input  result, cout, zero, neg_zero, equal, busy, done
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs one W-bit ALU operation as NIBBLES passes through a 4-bit slice, chaining
// slice carries between passes and reporting result, carry-out and compare flags.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_nibble_sequencer_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SHR = 3'd6;
    localparam logic [2:0] F_SHL = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  shadow_q, shadow_d;
    logic [W-1:0]  result_q, result_d;
    logic [2:0]    func_q, func_d;
    logic          com_q, com_d;
    logic          cin_q, cin_d;
    logic          carry_q, carry_d;
    logic          equ_q, equ_d;
    logic          cout_q, cout_d;
    logic          zero_q, zero_d;
    logic          neg_zero_q, neg_zero_d;
    logic          equal_q, equal_d;

    logic [IW-1:0] slot;
    logic [IW+1:0] base;
    logic          first_pass;
    logic          chain_right;
    logic          chain_left;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            shadow_q   <= '0;
            result_q   <= '0;
            func_q     <= '0;
            com_q      <= 1'b0;
            cin_q      <= 1'b0;
            carry_q    <= 1'b0;
            equ_q      <= 1'b0;
            cout_q     <= 1'b0;
            zero_q     <= 1'b0;
            neg_zero_q <= 1'b0;
            equal_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            shadow_q   <= shadow_d;
            result_q   <= result_d;
            func_q     <= func_d;
            com_q      <= com_d;
            cin_q      <= cin_d;
            carry_q    <= carry_d;
            equ_q      <= equ_d;
            cout_q     <= cout_d;
            zero_q     <= zero_d;
            neg_zero_q <= neg_zero_d;
            equal_q    <= equal_d;
        end
    end

    // Right shifts must walk MSB-first so the carry ripples downward through the word.
    always_comb begin
        slot        = (func_q == F_SHR) ? (IW'(NIBBLES - 1) - idx_q) : idx_q;
        base        = {slot, 2'b00};
        first_pass  = (idx_q == '0);
        chain_right = (func_q == F_ADD) || (func_q == F_SHL);
        chain_left  = (func_q == F_SHR);
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        a_d          = a_q;
        b_d          = b_q;
        shadow_d     = shadow_q;
        result_d     = result_q;
        func_d       = func_q;
        com_d        = com_q;
        cin_d        = cin_q;
        carry_d      = carry_q;
        equ_d        = equ_q;
        cout_d       = cout_q;
        zero_d       = zero_q;
        neg_zero_d   = neg_zero_q;
        equal_d      = equal_q;
        bus.alu_a        = '0;
        bus.alu_b        = '0;
        bus.alu_f        = '0;
        bus.alu_com      = 1'b0;
        bus.alu_ci_right = 1'b0;
        bus.alu_ci_left  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.opa;
                    b_d     = bus.opb;
                    func_d  = bus.func;
                    com_d   = bus.com;
                    cin_d   = bus.cin;
                    carry_d = 1'b0;
                    equ_d   = 1'b1;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                bus.alu_a   = a_q[base +: 4];
                bus.alu_b   = b_q[base +: 4];
                bus.alu_f   = func_q;
                bus.alu_com = com_q;
                if (chain_right) begin
                    bus.alu_ci_right = first_pass ? cin_q : carry_q;
                    carry_d          = bus.alu_co_left;
                end else if (chain_left) begin
                    bus.alu_ci_left  = first_pass ? cin_q : carry_q;
                    carry_d          = bus.alu_co_right;
                end else begin
                    carry_d          = 1'b0;
                end
                equ_d              = equ_q & bus.alu_equ;
                shadow_d[base +: 4] = bus.alu_d;
                if (idx_q == IW'(NIBBLES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                result_d   = shadow_q;
                cout_d     = carry_q;
                zero_d     = (shadow_q == '0);
                neg_zero_d = &shadow_q;
                equal_d    = equ_q;
                idx_d      = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.zero     = zero_q;
    assign bus.neg_zero = neg_zero_q;
    assign bus.equal    = equal_q;
endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Multi-cycle controller directly upstream of the 4-bit ALU slice. It runs one W-bit operation as a series of nibble passes through a single slice.
- Latches W-bit operands, function code, complement mode and carry-in. Each cycle it presents one nibble of A and B to the slice and captures the nibble result.
- Chains the slice carry outputs back into the carry inputs between nibbles.
- Produces the W-bit result, a carry-out, zero / negative-zero / equal flags, and a start/busy/done handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices per word; W = 4*NIBBLES; legal range 2..8.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request operation; sampled only when busy=0
- func  in  3  function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL
- com  in  1  ones-complement output mode
- cin  in  1  carry-in for ADD, shift-in bit for SHL/SHR
- opa  in  W  operand A
- opb  in  W  operand B
- alu_a  out  4  nibble of A to slice
- alu_b  out  4  nibble of B to slice
- alu_f  out  3  function code to slice
- alu_com  out  1  complement mode to slice
- alu_ci_right  out  1  slice right carry input
- alu_ci_left  out  1  slice left carry input
- alu_d  in  4  slice result nibble
- alu_co_left  in  1  slice left carry output
- alu_co_right  in  1  slice right carry output
- alu_equ  in  1  slice A=B nibble compare
- result  out  W  assembled result; held until next accepted start
- cout  out  1  final carry/shift-out
- zero  out  1  result == 0
- neg_zero  out  1  result == all ones
- equal  out  1  opa == opb
- busy  out  1  high in RUN and DONE
- done  out  1  single-cycle completion pulse

Behaviour:
- Reset (rst=1 at clock edge, any state, including mid-operation):
  - State goes to IDLE; index counter = 0.
  - result, cout, zero, neg_zero, equal, done, busy all 0.
  - All latched operands and modes are cleared to 0.
- States:
  - IDLE: busy=0. start=1 latches opa, opb, func, com, cin, clears the carry register and sets equal accumulator = 1. Next state RUN, idx=0. start=0 stays IDLE.
  - RUN: busy=1. Lasts exactly NIBBLES cycles. Each cycle the slice is driven from latched state, and at the edge alu_d is written into nibble slot k of a result shadow register. After the idx=NIBBLES-1 capture the next state is DONE.
  - DONE: busy=1, done=1 for exactly one cycle. The shadow is copied to result; cout, zero, neg_zero and equal update simultaneously. Next state IDLE.
- Latency: start sampled at edge E0; done is high during the cycle after edge E0+NIBBLES (5 cycles after start for NIBBLES=4). The minimum start-to-start spacing is NIBBLES+2 cycles.
- start while busy=1 (RUN or DONE) is ignored and has no effect on the current operation.
- Nibble order:
  - SHR (func 6): MSB first, k = NIBBLES-1-idx.
  - All other functions: LSB first, k = idx.
- Slice drive:
  - alu_a = A[4k+3:4k], alu_b = B[4k+3:4k]; alu_f = latched func; alu_com = latched com.
  - alu_ci_right: ADD/SHL use cin at idx=0, then the carry register; all other functions drive 0.
  - alu_ci_left: SHR uses cin at idx=0, then the carry register; all other functions drive 0.
  - IDLE/DONE: all alu_* outputs = 0.
- Carry register update each RUN cycle:
  - ADD/SHL load alu_co_left.
  - SHR loads alu_co_right.
  - All other functions load 0.
- cout = carry register value after the last nibble (0 for logic/pass functions).
- Complement mode: the slice computes the carry before inversion, so cout is never inverted. zero and neg_zero evaluate the final (post-inversion) result.
- equal = AND of alu_equ over all NIBBLES passes; it is independent of func and com.
- All arithmetic is modulo 2^W; there is no overflow flag.

Test Plan:
- NIBBLES=4, ADD, opa=0x1234, opb=0x0FCD, cin=0 -> result=0x2201, cout=0, zero=0, equal=0; done pulses exactly 5 cycles after start, one cycle wide.
- ADD opa=0xFFFF, opb=0x0001, cin=0 -> result=0x0000, cout=1, zero=1, neg_zero=0.
- SHL opa=0x8001, cin=1 -> result=0x0003, cout=1; SHR opa=0x8001, cin=0 -> result=0x4000, cout=1. Check that the alu_a sequence for SHR is 0x8, 0x0, 0x0, 0x1.
- XOR, com=1, opa=opb=0xA5A5 -> result=0xFFFF, neg_zero=1, zero=0, equal=1, cout=0.
- Pulse start again in RUN cycle 1 -> ignored; the first result is unaffected. Assert rst in RUN cycle 2 -> next cycle busy=0, result=0, done never pulses. A subsequent ADD 0x0001+0x0001 -> result=0x0002.
- Hold start=1 continuously -> operations are accepted only from IDLE, one every 6 cycles (NIBBLES=4), with one done pulse per operation.
